// File: rtl/i2c_target_rx_pkg.sv
// Shared definitions for the 7-bit-address I2C target receiver: FSM states
// and bus-level constants.
package i2c_target_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic       I2C_ACK           = 1'b0;
  localparam logic       I2C_NACK          = 1'b1;
  localparam logic       I2C_RW_READ       = 1'b1;
  localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge detector for one I2C line.
// Optional 3-sample majority filter when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       filt_in;
  logic       level_d;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[0], line_in};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic       maj_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '1;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      maj_q  <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                (hist_q[1] & hist_q[2]);
    end
  end

  assign filt_in = maj_q;
`else
  assign filt_in = sync_q[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      level   <= filt_in;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_target_rx.sv
// 7-bit-address I2C target: START/STOP detection, address match, ACK,
// write-byte delivery and read-byte shifting. Glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       nack_det
);

  import i2c_target_rx_pkg::*;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_n;
  logic [3:0] bit_cnt_q, bit_cnt_n, bit_cnt_inc;
  logic [7:0] shift_q, shift_n, shift_in;
  logic       rw_q, rw_n;
  logic       hold_q, hold_n;
  logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n, nack_n;
  logic [7:0] rx_data_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      hold_q    <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      nack_det  <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
      rw_q      <= rw_n;
      hold_q    <= hold_n;
      sda_oe    <= sda_oe_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      busy      <= busy_n;
      nack_det  <= nack_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    shift_n     = shift_q;
    rw_n        = rw_q;
    hold_n      = hold_q;
    sda_oe_n    = sda_oe;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    busy_n      = busy;
    nack_n      = 1'b0;
    bit_cnt_inc = bit_cnt_q + 4'd1;
    shift_in    = {shift_q[6:0], sda_lvl};

    case (state_q)
      ST_IDLE: ;

      ST_ADDR: begin
        if (scl_rise) begin
          shift_n = shift_in;
          if (bit_cnt_inc == I2C_BITS_PER_BYTE) begin
            bit_cnt_n = '0;
            hold_n    = 1'b0;
            if (shift_in[7:1] == TARGET_ADDR) begin
              state_n = ST_ADDR_ACK;
              rw_n    = shift_in[0];
              busy_n  = 1'b1;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt_inc;
          end
        end
      end

      // hold_q marks that the ACK is on the bus; the second SCL fall ends it.
      ST_ADDR_ACK, ST_WR_ACK: begin
        if (scl_fall) begin
          if (!hold_q) begin
            hold_n   = 1'b1;
            sda_oe_n = ~I2C_ACK;
          end else begin
            hold_n    = 1'b0;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
              tx_req_n = 1'b1;
              state_n  = ST_RD;
            end else begin
              state_n  = ST_WR;
            end
          end
        end
      end

      ST_WR: begin
        if (scl_rise) begin
          shift_n = shift_in;
          if (bit_cnt_inc == I2C_BITS_PER_BYTE) begin
            rx_data_n  = shift_in;
            rx_valid_n = 1'b1;
            bit_cnt_n  = '0;
            hold_n     = 1'b0;
            state_n    = ST_WR_ACK;
          end else begin
            bit_cnt_n  = bit_cnt_inc;
          end
        end
      end

      // The cycle tx_req is high is the load cycle for the fabric byte.
      ST_RD: begin
        if (tx_req) begin
          shift_n   = tx_data;
          sda_oe_n  = ~tx_data[7];
          bit_cnt_n = '0;
        end else if (scl_fall) begin
          if (bit_cnt_inc == I2C_BITS_PER_BYTE) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            hold_n    = 1'b0;
            state_n   = ST_RD_ACK;
          end else begin
            bit_cnt_n = bit_cnt_inc;
            shift_n   = {shift_q[6:0], 1'b0};
            sda_oe_n  = ~shift_q[6];
          end
        end
      end

      ST_RD_ACK: begin
        if (scl_rise) begin
          if (sda_lvl == I2C_NACK) begin
            nack_n  = 1'b1;
            state_n = ST_WAIT_STOP;
          end else begin
            hold_n  = 1'b1;
          end
        end else if (scl_fall && hold_q) begin
          hold_n   = 1'b0;
          tx_req_n = 1'b1;
          state_n  = ST_RD;
        end
      end

      ST_WAIT_STOP: ;

      default: state_n = ST_IDLE;
    endcase

    // START/STOP take priority over anything decided above, including byte completion.
    if (start_det || stop_det) begin
      state_n    = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_n  = '0;
      hold_n     = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      nack_n     = 1'b0;
      rx_data_n  = rx_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: bit-banged I2C controller, table of
// write transactions, scoreboard queues for rx/tx bytes, hand-written corner cases.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_req, busy, nack_det;

  int total = 0;
  int bad   = 0;
  int n_rx = 0, n_txreq = 0, n_nack = 0, n_oe = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_exp[$];

  always #10 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h50)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .busy     (busy),
    .nack_det (nack_det)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: pop expected results when the DUT produces them.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      check("rx_valid_expected", (rx_q.size() > 0), 1);
      if (rx_q.size() > 0) check("rx_data", rx_data, rx_q.pop_front());
    end
    if (tx_req) begin
      n_txreq++;
      tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
    end
    if (nack_det) n_nack++;
    if (sda_oe) n_oe++;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, input logic glitch, output logic s);
    sda_m = b;
    clks(8);
    scl_m = 1'b1;
    if (glitch) begin
      clks(4); scl_m = 1'b0; clks(1); scl_m = 1'b1; clks(3);
    end else begin
      clks(8);
    end
    s = sda_in;
    clks(8);
    scl_m = 1'b0;
    clks(8);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; clks(16); scl_m = 1'b0; clks(8);
  endtask

  task automatic i2c_rep_start();
    sda_m = 1'b1; clks(8); scl_m = 1'b1; clks(16); sda_m = 1'b0; clks(16);
    scl_m = 1'b0; clks(8);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(8); scl_m = 1'b1; clks(16); sda_m = 1'b1; clks(16);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(d[i], 1'b0, s);
      check("wr_line", s, d[i]);
    end
    bit_cycle(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_cycle(mack, 1'b0, s);
    check("rd_ack_line", s, mack);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  initial begin
    wr_vec_t    vecs[5];
    logic       a;
    logic [7:0] d;
    int         rx0, oe0, tr0, nk0;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1};
    vecs[1] = '{8'hA2, 8'h55, 1'b0};
    vecs[2] = '{8'hA0, 8'hFF, 1'b1};
    vecs[3] = '{8'hA0, 8'h00, 1'b1};
    vecs[4] = '{8'h50, 8'h12, 1'b0};
    tx_data = 8'h00;

    clks(4);
    check("rst_sda_oe",   sda_oe,   0);
    check("rst_rx_data",  rx_data,  0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req",   tx_req,   0);
    check("rst_busy",     busy,     0);
    check("rst_nack_det", nack_det, 0);
    reset = 1'b1;
    clks(8);

    for (int v = 0; v < 5; v++) begin
      rx0 = n_rx; oe0 = n_oe;
      if (vecs[v].exp_ack) rx_q.push_back(vecs[v].data);
      i2c_start();
      write_byte(vecs[v].addr, a);
      check("addr_ack", a, vecs[v].exp_ack ? 1'b0 : 1'b1);
      check("busy_after_addr", busy, vecs[v].exp_ack);
      write_byte(vecs[v].data, a);
      check("data_ack", a, vecs[v].exp_ack ? 1'b0 : 1'b1);
      i2c_stop();
      clks(4);
      check("busy_after_stop", busy, 0);
      check("oe_after_stop", sda_oe, 0);
      check("rx_count", n_rx - rx0, vecs[v].exp_ack ? 1 : 0);
      if (!vecs[v].exp_ack) check("oe_never", n_oe - oe0, 0);
      check("rx_q_drained", rx_q.size(), 0);
    end

    // Read: two bytes, controller ACKs the first and NACKs the second.
    tr0 = n_txreq; nk0 = n_nack;
    tx_q.push_back(8'h96); rd_exp.push_back(8'h96);
    tx_q.push_back(8'h5A); rd_exp.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, a);
    check("rd_addr_ack", a, 0);
    read_byte(1'b0, d);
    check("rd_byte0", d, rd_exp.pop_front());
    read_byte(1'b1, d);
    check("rd_byte1", d, rd_exp.pop_front());
    i2c_stop();
    clks(4);
    check("rd_tx_req_count", n_txreq - tr0, 2);
    check("rd_nack_count", n_nack - nk0, 1);
    check("rd_busy_after_stop", busy, 0);

    // Repeated START between a write and a read.
    rx0 = n_rx; tr0 = n_txreq;
    rx_q.push_back(8'h11);
    i2c_start();
    write_byte(8'hA0, a);
    check("rs_addr_ack", a, 0);
    write_byte(8'h11, a);
    check("rs_data_ack", a, 0);
    i2c_rep_start();
    tx_q.push_back(8'h77); rd_exp.push_back(8'h77);
    write_byte(8'hA1, a);
    check("rs_rd_addr_ack", a, 0);
    check("rs_busy", busy, 1);
    read_byte(1'b1, d);
    check("rs_rd_byte", d, rd_exp.pop_front());
    i2c_stop();
    clks(4);
    check("rs_rx_count", n_rx - rx0, 1);
    check("rs_tx_req_count", n_txreq - tr0, 1);

    // STOP after 4 bits of a write byte.
    rx0 = n_rx;
    i2c_start();
    write_byte(8'hA0, a);
    check("mid_addr_ack", a, 0);
    bit_cycle(1'b1, 1'b0, a);
    bit_cycle(1'b0, 1'b0, a);
    bit_cycle(1'b1, 1'b0, a);
    bit_cycle(1'b1, 1'b0, a);
    i2c_stop();
    clks(4);
    check("mid_rx_count", n_rx - rx0, 0);
    check("mid_sda_oe", sda_oe, 0);
    check("mid_busy", busy, 0);

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'hA0;
      bit_cycle(d[i], 1'b0, a);
    end
    sda_m = 1'b1;
    clks(4);
    check("ack_driven_before_reset", sda_oe, 1);
    reset = 1'b0;
    #1;
    check("reset_releases_sda", sda_oe, 0);
    check("reset_clears_busy", busy, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    clks(4);
    reset = 1'b1;
    clks(8);

    // 1-clk low glitch on SCL during the first address bit's high phase.
    i2c_start();
    bit_cycle(1'b1, 1'b1, a);
    d = 8'hA0;
    for (int i = 6; i >= 0; i--) bit_cycle(d[i], 1'b0, a);
    bit_cycle(1'b1, 1'b0, a);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("glitch_filtered_ack", a, 0);
`else
    check("glitch_extra_edge_nack", a, 1);
`endif
    i2c_stop();
    clks(4);
    check("glitch_sda_oe", sda_oe, 0);

    check("final_rx_q_empty", rx_q.size(), 0);
    check("final_tx_q_empty", tx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
